button_conditioner: RTL
=======================

// Module: button_conditioner
// PURPOSE
//  Input front-end for the alarm clock system: conditions the raw push-buttons and
//  produces the clean levels/strobes that feed button1..4_export. Per button:
//  2-FF synchroniser, debounce, press/release/long-press strobes, hold auto-repeat,
//  and a sticky event flag the CPU polls and clears.
// PARAMETERS
//  NUM_BTN      4           number of independent button channels
//  ACTIVE_LOW   1           1: raw pin reads 0 when pressed; 0: reads 1 when pressed
//  DEBOUNCE_CYC 1_000_000   cycles the synchronised input must stay stable (20 ms @ 50 MHz)
//  HOLD_CYC     50_000_000  cycles pressed before long-press / first repeat (1 s)
//  REPEAT_CYC   10_000_000  cycles between auto-repeat strobes while held (200 ms)
// PORTS
//  clk_clk       in   1        system clock; all logic on rising edge
//  reset_reset   in   1        synchronous, active-high reset
//  btn_raw       in   NUM_BTN  asynchronous raw button pins
//  evt_clear     in   NUM_BTN  1-cycle pulse per bit: clear evt_pending[i]
//  btn_level     out  NUM_BTN  debounced level, 1 = pressed (drives buttonN_export)
//  btn_press     out  NUM_BTN  1-cycle strobe: debounced press and each auto-repeat
//  btn_release   out  NUM_BTN  1-cycle strobe: debounced release
//  btn_long      out  NUM_BTN  1-cycle strobe: hold reached HOLD_CYC (once per press)
//  evt_pending   out  NUM_BTN  sticky: set by btn_press, cleared by evt_clear
// BEHAVIOUR
//  - Reset: all outputs 0, sync FFs loaded with "released" value, FSMs IDLE, counters 0.
//  - Sync: 2 FFs, then polarity fold (ACTIVE_LOW) -> p (1 = pressed). Pin-to-p latency 2 clk.
//  - Per-channel FSM, one counter cnt (width clog2 of max(HOLD_CYC,DEBOUNCE_CYC)+1):
//    IDLE:    p=1 -> ARM, cnt=0.
//    ARM:     p=0 -> IDLE (glitch rejected, no strobe). cnt==DEBOUNCE_CYC-1 -> PRESSED,
//             btn_level<=1, btn_press pulse, cnt=0. else cnt++.
//    PRESSED: p=0 -> DISARM, cnt=0. cnt==HOLD_CYC-1 -> HOLD, btn_long + btn_press pulse,
//             cnt=0. else cnt++.
//    HOLD:    p=0 -> DISARM, cnt=0. cnt==REPEAT_CYC-1 -> btn_press pulse, cnt=0. else cnt++.
//    DISARM:  p=1 -> back to state held before DISARM (PRESSED or HOLD), cnt=0
//             (hold timing restarts; no new press strobe). cnt==DEBOUNCE_CYC-1 -> IDLE,
//             btn_level<=0, btn_release pulse. else cnt++.
//  - btn_level changes only on debounce completion; strobes are registered, asserted
//    the cycle after the transition condition, exactly 1 cycle wide.
//  - Press lands DEBOUNCE_CYC+2 cycles after a clean pin edge; release likewise.
//  - evt_pending[i]: next = btn_press[i] | (evt_pending[i] & ~evt_clear[i]);
//    set and clear in the same cycle -> stays 1 (event never lost).
//  - evt_clear on a bit already 0: no effect. Channels fully independent; simultaneous
//    presses on all channels produce simultaneous strobes.
//  - Reset mid-press: channel returns to IDLE with btn_level=0, no release strobe; if pin
//    still pressed, a fresh press is reported after full debounce.
//  - Counters saturate-free by construction (cleared on every compare hit/state change).
//  - Parameter rule: DEBOUNCE_CYC>=1, HOLD_CYC>=1, REPEAT_CYC>=1; elaboration error otherwise.
// STRUCTURE
//  - Package alarm_input_pkg: btn_state_t enum {IDLE,ARM,PRESSED,HOLD,DISARM},
//    function cnt_width(max_cycles).
//  - Sub-module button_channel (one button: sync, FSM, counter, strobes, sticky flag);
//    top instantiates NUM_BTN copies via generate and concatenates outputs.
// TESTING (bench uses DEBOUNCE_CYC=4, HOLD_CYC=20, REPEAT_CYC=5, ACTIVE_LOW=1)
//  1 Reset: assert reset_reset 2 cycles with btn_raw=4'b0000 -> all outputs 0, then press
//    reported 4+2 cycles after release of reset with btn_level=1.
//  2 Glitch: btn_raw[0] low for 3 cycles then high -> no btn_press, btn_level[0] stays 0.
//  3 Clean press/release ch1: low 10 cycles -> btn_press[1] pulse at cycle 6, level 1;
//    high -> btn_release[1] pulse 6 cycles later, level 0; evt_pending[1]=1 until clear.
//  4 Hold ch2 for 40 cycles: press at 6, btn_long+press at 26, repeats at 31,36,41;
//    btn_long exactly once.
//  5 Bounce on release: during HOLD, 2-cycle high glitch -> no release strobe, hold
//    timer restarts (next repeat 5 cycles after glitch end).
//  6 Sticky race: btn_press[3] and evt_clear[3] same cycle -> evt_pending[3]=1; clear
//    alone next cycle -> 0; all 4 channels pressed together -> 4 simultaneous strobes.

Source files
------------

// File: rtl/button_conditioner_pkg.sv
// Shared types and helpers for the alarm clock button front-end.
// State encodings are fixed so they can also be used as plain logic [2:0] constants.
package alarm_input_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARM     = 3'd1,
    PRESSED = 3'd2,
    HOLD    = 3'd3,
    DISARM  = 3'd4
  } btn_state_t;

  // Bits needed to hold a count of 0..max_cycles.
  function automatic int cnt_width(input int max_cycles);
    return (max_cycles < 1) ? 1 : $clog2(max_cycles + 1);
  endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Button bundle between the pins/CPU side and the conditioner.
// The master side drives raw pins and clears; the slave side returns levels, strobes and flags.
interface button_conditioner_if #(
  parameter int NUM_BTN = 4
);
  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] evt_clear;
  logic [NUM_BTN-1:0] btn_level;
  logic [NUM_BTN-1:0] btn_press;
  logic [NUM_BTN-1:0] btn_release;
  logic [NUM_BTN-1:0] btn_long;
  logic [NUM_BTN-1:0] evt_pending;

  modport master (
    output btn_raw, evt_clear,
    input  btn_level, btn_press, btn_release, btn_long, evt_pending
  );

  modport slave (
    input  btn_raw, evt_clear,
    output btn_level, btn_press, btn_release, btn_long, evt_pending
  );
endinterface

// File: rtl/button_conditioner_channel.sv
// One button channel: 2-FF synchroniser, debounce FSM with long-press and auto-repeat,
// registered 1-cycle strobes and a sticky event flag cleared by the CPU.
module button_channel
  import alarm_input_pkg::*;
#(
  parameter bit ACTIVE_LOW   = 1'b1,
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int HOLD_CYC     = 50_000_000,
  parameter int REPEAT_CYC   = 10_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  input  logic evt_clear,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_long,
  output logic evt_pending
);

  localparam int MAX_AB  = (HOLD_CYC > DEBOUNCE_CYC) ? HOLD_CYC : DEBOUNCE_CYC;
  localparam int MAX_CYC = (REPEAT_CYC > MAX_AB) ? REPEAT_CYC : MAX_AB;
  localparam int CW      = cnt_width(MAX_CYC);

  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYC - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYC - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  localparam logic [2:0] S_IDLE    = IDLE;
  localparam logic [2:0] S_ARM     = ARM;
  localparam logic [2:0] S_PRESSED = PRESSED;
  localparam logic [2:0] S_HOLD    = HOLD;
  localparam logic [2:0] S_DISARM  = DISARM;

  localparam logic [1:0] SYNC_RELEASED = {2{ACTIVE_LOW}};

  logic [1:0]    sync;
  logic          p;
  logic [2:0]    state;
  logic [2:0]    ret_state;
  logic [CW-1:0] cnt;

  assign p = sync[1] ^ ACTIVE_LOW;

  // ret_state remembers whether a bounce during release returns to PRESSED or HOLD.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync        <= SYNC_RELEASED;
      state       <= S_IDLE;
      ret_state   <= S_PRESSED;
      cnt         <= '0;
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
      btn_long    <= 1'b0;
      evt_pending <= 1'b0;
    end else begin
      sync        <= {sync[0], btn_raw};
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
      btn_long    <= 1'b0;
      evt_pending <= btn_press | (evt_pending & ~evt_clear);

      case (state)
        S_IDLE: begin
          if (p) begin
            state <= S_ARM;
            cnt   <= '0;
          end
        end

        S_ARM: begin
          if (!p) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else if (cnt == DEB_LAST) begin
            state     <= S_PRESSED;
            btn_level <= 1'b1;
            btn_press <= 1'b1;
            cnt       <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        S_PRESSED: begin
          if (!p) begin
            state     <= S_DISARM;
            ret_state <= S_PRESSED;
            cnt       <= '0;
          end else if (cnt == HOLD_LAST) begin
            state     <= S_HOLD;
            btn_long  <= 1'b1;
            btn_press <= 1'b1;
            cnt       <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        S_HOLD: begin
          if (!p) begin
            state     <= S_DISARM;
            ret_state <= S_HOLD;
            cnt       <= '0;
          end else if (cnt == REP_LAST) begin
            btn_press <= 1'b1;
            cnt       <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        S_DISARM: begin
          if (p) begin
            state <= ret_state;
            cnt   <= '0;
          end else if (cnt == DEB_LAST) begin
            state       <= S_IDLE;
            btn_level   <= 1'b0;
            btn_release <= 1'b1;
            cnt         <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        default: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Alarm clock button front-end: NUM_BTN independent conditioned channels
// whose per-bit outputs are gathered onto the button bundle.
module button_conditioner #(
  parameter int NUM_BTN      = 4,
  parameter bit ACTIVE_LOW   = 1'b1,
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int HOLD_CYC     = 50_000_000,
  parameter int REPEAT_CYC   = 10_000_000
) (
  input logic                 clk_clk,
  input logic                 reset_reset,
  button_conditioner_if.slave bus
);

  if (DEBOUNCE_CYC < 1 || HOLD_CYC < 1 || REPEAT_CYC < 1) begin : g_bad_params
    $error("button_conditioner: DEBOUNCE_CYC, HOLD_CYC and REPEAT_CYC must all be >= 1");
  end

  logic [NUM_BTN-1:0] level_w;
  logic [NUM_BTN-1:0] press_w;
  logic [NUM_BTN-1:0] release_w;
  logic [NUM_BTN-1:0] long_w;
  logic [NUM_BTN-1:0] pending_w;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    button_channel #(
      .ACTIVE_LOW   (ACTIVE_LOW),
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .HOLD_CYC     (HOLD_CYC),
      .REPEAT_CYC   (REPEAT_CYC)
    ) u_channel (
      .clk         (clk_clk),
      .rst         (reset_reset),
      .btn_raw     (bus.btn_raw[i]),
      .evt_clear   (bus.evt_clear[i]),
      .btn_level   (level_w[i]),
      .btn_press   (press_w[i]),
      .btn_release (release_w[i]),
      .btn_long    (long_w[i]),
      .evt_pending (pending_w[i])
    );
  end

  assign bus.btn_level   = level_w;
  assign bus.btn_press   = press_w;
  assign bus.btn_release = release_w;
  assign bus.btn_long    = long_w;
  assign bus.evt_pending = pending_w;

endmodule
